// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer
// Receives the serial result stream of the MTM ALU on sin and decodes it.
// A packet is 4 DATA frames followed by 1 CTL frame. An error response is a
// single CTL frame with bit 7 set. Each frame is 11 bits: start(0), type,
// 8 payload bits MSB first, and stop(1).
// Results are presented on C/flags/crc with a one-cycle out_valid pulse.
// Error responses are presented on err_flags with an err_valid pulse.
// Malformed frames or sequences produce a frame_err pulse.
// Optional feature: define DESER_CRC_CHECK_EN to verify the CRC3 of each
// result packet before it is accepted.

module mtm_alu_deserializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] C,
    output logic [3:0]  flags,
    output logic [2:0]  crc,
    output logic        err_valid,
    output logic [5:0]  err_flags,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TYPE,
        S_PAYLOAD,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        type_q, type_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  frame_cnt_q, frame_cnt_d;
    logic [31:0] data_q, data_d;
    logic        need_high_q, need_high_d;
    logic [31:0] c_q, c_d;
    logic [3:0]  flags_q, flags_d;
    logic [2:0]  crc_q, crc_d;
    logic [5:0]  err_flags_q, err_flags_d;
    logic        out_valid_q, out_valid_d;
    logic        err_valid_q, err_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        crc_ok;

`ifdef DESER_CRC_CHECK_EN
    // CRC3 with polynomial x^3+x+1 and init 0, fed MSB first.
    function automatic logic [2:0] crc3_calc(input logic [36:0] bits);
        logic [2:0] r;
        logic       fb;
        r = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = r[2] ^ bits[i];
            r  = {r[1], r[0] ^ fb, fb};
        end
        return r;
    endfunction

    // The check covers the assembled result word, a zero pad bit and the flags.
    assign crc_ok = (crc3_calc({data_q, 1'b0, shift_q[6:3]}) == shift_q[2:0]);
`else
    // Without the check, the received crc field is passed through untouched.
    assign crc_ok = 1'b1;
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            type_q      <= 1'b0;
            shift_q     <= 8'd0;
            frame_cnt_q <= 3'd0;
            data_q      <= 32'd0;
            // The line must be seen high before a start bit is accepted, so
            // the tail of a frame cut short by reset is not decoded as a frame.
            need_high_q <= 1'b1;
            c_q         <= 32'd0;
            flags_q     <= 4'd0;
            crc_q       <= 3'd0;
            err_flags_q <= 6'd0;
            out_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, so their order in this block does not matter.
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            type_q      <= type_d;
            shift_q     <= shift_d;
            frame_cnt_q <= frame_cnt_d;
            data_q      <= data_d;
            need_high_q <= need_high_d;
            c_q         <= c_d;
            flags_q     <= flags_d;
            crc_q       <= crc_d;
            err_flags_q <= err_flags_d;
            out_valid_q <= out_valid_d;
            err_valid_q <= err_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Frame FSM, packet sequencing and output updates.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. Any path
        // that leaves a signal unassigned would otherwise infer a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        type_d      = type_q;
        shift_d     = shift_q;
        frame_cnt_d = frame_cnt_q;
        data_d      = data_q;
        need_high_d = need_high_q;
        c_d         = c_q;
        flags_d     = flags_q;
        crc_d       = crc_q;
        err_flags_d = err_flags_q;
        out_valid_d = 1'b0;
        err_valid_d = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (need_high_q) begin
                    if (sin) begin
                        need_high_d = 1'b0;
                    end
                end else if (!sin) begin
                    state_d = S_TYPE;
                end
            end

            S_TYPE: begin
                type_d    = sin;
                bit_cnt_d = 3'd0;
                state_d   = S_PAYLOAD;
            end

            S_PAYLOAD: begin
                shift_d   = {shift_q[6:0], sin};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                // IDLE is reached straight from here, so a start bit in the
                // next cycle is accepted and back-to-back frames need no gap.
                state_d = S_IDLE;
                if (!sin) begin
                    // Broken stop bit: resynchronise on the next high line.
                    frame_err_d = 1'b1;
                    frame_cnt_d = 3'd0;
                    need_high_d = 1'b1;
                end else if (!type_q) begin
                    // DATA frame: collect up to four bytes, first byte on top.
                    if (frame_cnt_q < 3'd4) begin
                        unique case (frame_cnt_q[1:0])
                            2'd0: data_d[31:24] = shift_q;
                            2'd1: data_d[23:16] = shift_q;
                            2'd2: data_d[15:8]  = shift_q;
                            2'd3: data_d[7:0]   = shift_q;
                        endcase
                        frame_cnt_d = frame_cnt_q + 3'd1;
                    end else begin
                        frame_err_d = 1'b1;
                        frame_cnt_d = 3'd0;
                    end
                end else if (!shift_q[7]) begin
                    // Result CTL: closes a packet of exactly four DATA frames.
                    if ((frame_cnt_q == 3'd4) && crc_ok) begin
                        c_d         = data_q;
                        flags_d     = shift_q[6:3];
                        crc_d       = shift_q[2:0];
                        out_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    frame_cnt_d = 3'd0;
                end else begin
                    // Error CTL: only valid as a stand-alone frame.
                    if (frame_cnt_q == 3'd0) begin
                        err_flags_d = shift_q[6:1];
                        err_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    frame_cnt_d = 3'd0;
                end
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign C         = c_q;
    assign flags     = flags_q;
    assign crc       = crc_q;
    assign err_valid = err_valid_q;
    assign err_flags = err_flags_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer
// Drives the serial line one bit per clock. Each frame outcome is compared
// against a frame-level reference model of the packet rules. The test starts
// with directed scenarios and then runs randomized frame sequences.

module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sin = 1'b1;
    logic        out_valid;
    logic [31:0] C;
    logic [3:0]  flags;
    logic [2:0]  crc;
    logic        err_valid;
    logic [5:0]  err_flags;
    logic        frame_err;

    mtm_alu_deserializer dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .out_valid (out_valid),
        .C         (C),
        .flags     (flags),
        .crc       (crc),
        .err_valid (err_valid),
        .err_flags (err_flags),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ov_cyc[$];

    // Clock edge counter and out_valid timestamps, sampled mid-cycle.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (out_valid) ov_cyc.push_back(cyc);

    // Reference model state: frames collected so far and held outputs.
    logic [7:0]  m_data [4];
    int          m_n;
    logic [31:0] m_c;
    logic [3:0]  m_flags;
    logic [2:0]  m_crc;
    logic [5:0]  m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_n     = 0;
        m_c     = 32'd0;
        m_flags = 4'd0;
        m_crc   = 3'd0;
        m_err   = 6'd0;
        for (int i = 0; i < 4; i++) m_data[i] = 8'd0;
    endtask

    // Apply the packet rules to one complete frame and predict the pulses.
    task automatic model_frame(input logic t, input logic [7:0] b, input logic s,
                               output logic ov, output logic ev, output logic fe);
        ov = 1'b0;
        ev = 1'b0;
        fe = 1'b0;
        if (!s) begin
            fe  = 1'b1;
            m_n = 0;
        end else if (!t) begin
            if (m_n < 4) begin
                m_data[m_n] = b;
                m_n++;
            end else begin
                fe  = 1'b1;
                m_n = 0;
            end
        end else if (!b[7]) begin
            if (m_n == 4) begin
                ov      = 1'b1;
                m_c     = {m_data[0], m_data[1], m_data[2], m_data[3]};
                m_flags = b[6:3];
                m_crc   = b[2:0];
            end else begin
                fe = 1'b1;
            end
            m_n = 0;
        end else begin
            if (m_n == 0) begin
                ev    = 1'b1;
                m_err = b[6:1];
            end else begin
                fe  = 1'b1;
                m_n = 0;
            end
        end
    endtask

    task automatic send_bit(input logic b, inout int pulses);
        sin = b;
        @(posedge clk);
        #1;
        pulses += int'(out_valid) + int'(err_valid) + int'(frame_err);
    endtask

    task automatic idle(input int n);
        int p;
        p = 0;
        for (int i = 0; i < n; i++) send_bit(1'b1, p);
        if (n > 0) check("quiet_idle", p, 0);
    endtask

    task automatic send_frame(input logic t, input logic [7:0] b, input logic s);
        logic [10:0] bits;
        int          p;
        logic        ov, ev, fe;
        bits = {1'b0, t, b, s};
        p = 0;
        for (int i = 10; i >= 1; i--) send_bit(bits[i], p);
        check("quiet_frame", p, 0);
        sin = bits[0];
        @(posedge clk);
        #1;
        model_frame(t, b, s, ov, ev, fe);
        check("out_valid", out_valid, ov);
        check("err_valid", err_valid, ev);
        check("frame_err", frame_err, fe);
        check("C", C, m_c);
        check("flags", flags, m_flags);
        check("crc", crc, m_crc);
        check("err_flags", err_flags, m_err);
    endtask

    task automatic send_packet(input logic [31:0] d, input logic [7:0] ctl);
        for (int i = 0; i < 4; i++) send_frame(1'b0, d[31-8*i -: 8], 1'b1);
        send_frame(1'b1, ctl, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_err_valid"}, err_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_C"}, C, 0);
        check({tag, "_flags"}, flags, 0);
        check({tag, "_crc"}, crc, 0);
        check({tag, "_err_flags"}, err_flags, 0);
    endtask

    // One-cycle reset pulse with the line idle; all outputs must clear.
    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        sin = 1'b1;
        @(posedge clk);
        #1;
        check_zero(tag);
        model_reset();
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          p;
        int          kind;
        int          gap;
        logic        need_gap;
        logic [31:0] d;

        model_reset();
        rst = 1'b0;
        sin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        idle(2);

        // Reference packet: result 0x12345678 with CTL 0x0D, plus 55-cycle latency.
        ov_cyc.delete();
        t0 = cyc;
        send_packet(32'h12345678, 8'h0D);
        idle(2);
        check("ref_ov_count", ov_cyc.size(), 1);
        if (ov_cyc.size() > 0) check("ref_latency", ov_cyc[0] - t0, 55);
        check("ref_C", C, 32'h12345678);
        check("ref_flags", flags, 4'b0001);
        check("ref_crc", crc, 3'b101);

        // Stand-alone error response 0xC9; the result word must be held.
        send_frame(1'b1, 8'hC9, 1'b1);
        check("err_flags_c9", err_flags, 6'b100100);
        check("err_C_held", C, 32'h12345678);
        idle(1);

        // Two packets back to back with no idle gap.
        ov_cyc.delete();
        send_packet(32'hDEADBEEF, 8'h0D);
        send_packet(32'hCAFEF00D, 8'h52);
        idle(2);
        check("b2b_ov_count", ov_cyc.size(), 2);
        if (ov_cyc.size() == 2) check("b2b_spacing", ov_cyc[1] - ov_cyc[0], 55);

        // Broken stop bit on the 2nd DATA frame. The low line that follows must
        // not start a frame. A good packet afterwards must decode normally.
        ov_cyc.delete();
        send_frame(1'b0, 8'hA1, 1'b1);
        send_frame(1'b0, 8'hB2, 1'b0);
        p = 0;
        for (int i = 0; i < 3; i++) send_bit(1'b0, p);
        check("hold_idle_low", p, 0);
        idle(2);
        check("bad_stop_no_ov", ov_cyc.size(), 0);
        send_packet(32'h0BADF00D, 8'h3B);
        idle(1);

        // Result CTL after only three DATA frames; the counter must restart.
        send_frame(1'b0, 8'h11, 1'b1);
        send_frame(1'b0, 8'h22, 1'b1);
        send_frame(1'b0, 8'h33, 1'b1);
        send_frame(1'b1, 8'h0D, 1'b1);
        send_packet(32'h55AA33CC, 8'h7E);
        idle(1);

        // Reset in the middle of the 3rd frame's payload, then a clean packet.
        send_frame(1'b0, 8'h44, 1'b1);
        send_frame(1'b0, 8'h55, 1'b1);
        p = 0;
        send_bit(1'b0, p);
        send_bit(1'b0, p);
        send_bit(1'b1, p);
        send_bit(1'b0, p);
        send_bit(1'b1, p);
        check("pre_reset_quiet", p, 0);
        pulse_reset("mid_reset");
        idle(2);
        send_packet(32'h87654321, 8'h2C);
        idle(1);

        // Randomized frame sequences.
        for (int k = 0; k < 60; k++) begin
            need_gap = 1'b0;
            kind = $urandom_range(0, 19);
            if (kind < 10) begin
                d = $urandom;
                send_packet(d, {1'b0, 7'($urandom)});
            end else if (kind < 13) begin
                send_frame(1'b1, {1'b1, 7'($urandom)}, 1'b1);
            end else if (kind < 17) begin
                send_frame(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
            end else if (kind < 19) begin
                send_frame(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
                need_gap = 1'b1;
            end else begin
                p = 0;
                send_bit(1'b0, p);
                for (int i = 0; i < $urandom_range(1, 8); i++)
                    send_bit(1'($urandom_range(0, 1)), p);
                check("rand_partial_quiet", p, 0);
                pulse_reset("rand_reset");
                need_gap = 1'b1;
            end
            gap = $urandom_range(0, 2);
            if (need_gap && gap == 0) gap = 1;
            idle(gap);
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mtm_alu_deserializer.md
MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-003 SHALL have port sin, input, 1, serial ALU result line, one bit per clk, idle high.
REQ-004 SHALL have port out_valid, output, 1, one-cycle pulse: result packet complete.
REQ-005 SHALL have port C, output, 32, result word, first data byte = C[31:24].
REQ-006 SHALL have port flags, output, 4, {carry, overflow, zero, negative} from the CTL frame.
REQ-007 SHALL have port crc, output, 3, CTL frame bits [2:0].
REQ-008 SHALL have port err_valid, output, 1, one-cycle pulse: error-response packet received.
REQ-009 SHALL have port err_flags, output, 6, error-CTL bits [6:1].
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse: malformed frame or sequence.

Function
REQ-011 SHALL decode 11-bit frames: start(0), type (0=DATA, 1=CTL), 8 payload bits MSB first, stop(1).
REQ-012 SHALL use FSM states IDLE, TYPE, PAYLOAD, STOP.
REQ-013 IDLE: sin=0 -> TYPE; sin=1 -> stay.
REQ-014 TYPE: latch the type bit and clear the bit counter -> PAYLOAD.
REQ-015 PAYLOAD: shift sin into the byte register each cycle; after 8 bits -> STOP.
REQ-016 SHALL accept a start bit in the cycle immediately after a stop bit, so back-to-back packets run 55 clk per 5 frames.
REQ-017 SHALL keep a frame counter 0..4; each DATA frame with counter <4 stores its byte into C[31-8n -: 8] and increments the counter.
REQ-018 A CTL frame with counter=4 and bit7=0 SHALL update C, flags and crc, and pulse out_valid in the cycle after its stop bit is sampled.
REQ-019 A CTL frame with counter=0 and bit7=1 SHALL update err_flags and pulse err_valid in the cycle after its stop bit is sampled.
REQ-020 Stop bit sampled 0 SHALL pulse frame_err, clear the counter, return to IDLE, and hold IDLE until sin=1 has been seen.
REQ-021 A DATA frame with counter=4, a CTL bit7=0 frame with counter<4, or a CTL bit7=1 frame with counter>0 SHALL pulse frame_err and clear the counter.
REQ-022 Simultaneous conditions: frame_err has priority; out_valid and err_valid SHALL never both assert in one cycle.
REQ-023 C, flags, crc and err_flags SHALL hold their last value until the next valid update.
REQ-024 SHALL have latency of stop bit of the CTL frame sampled -> out_valid on the next clk.

Reset
REQ-025 rst=0 at a clock edge SHALL force IDLE, counters 0, all outputs 0, regardless of any frame in progress.
REQ-026 After reset release, a partially received frame SHALL be ignored until a fresh start bit arrives.

Configuration
REQ-027 When DESER_CRC_CHECK_EN is defined, the block SHALL compute CRC3 over the 37 bits {C, 1'b0, flags}, MSB first, with polynomial x^3+x+1 and init 0; on mismatch with crc it SHALL pulse frame_err instead of out_valid.
REQ-028 When DESER_CRC_CHECK_EN is undefined, crc SHALL pass through unchecked and no CRC logic SHALL be present.

Verification
REQ-029 Bench SHALL cover: packet C=0x12345678, CTL=0x0D (carry=0, ovf=0, zero=0, neg=1, crc=5) -> out_valid once, C=0x12345678, flags=4'b0001, crc=3'b101, 55 clk after the first start bit.
REQ-030 Bench SHALL cover: a single CTL frame 0xC9 -> err_valid once, err_flags=6'b100100, C unchanged.
REQ-031 Bench SHALL cover: two packets back-to-back with no idle gap -> two out_valid pulses, 55 clk apart.
REQ-032 Bench SHALL cover: stop bit forced 0 on the 2nd DATA frame -> frame_err pulse, no out_valid; a following good packet decodes correctly.
REQ-033 Bench SHALL cover: CTL bit7=0 frame after 3 DATA frames -> frame_err, counter cleared.
REQ-034 Bench SHALL cover: rst=0 asserted mid-PAYLOAD of the 3rd frame -> all outputs 0 next clk; the next full packet decodes correctly.
